max_stream_ctrl: RTL and testbench
==================================

MAX_STREAM_CTRL -- requirements
Module: max_stream_ctrl

Interface
REQ-001 SHALL have parameter DW, default 6, sample width in bits.
REQ-002 SHALL have parameter LW, default 4, width of the frame-length and index fields.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous, active-high reset.
REQ-005 SHALL have port cfg_len, input, LW bits, frame length; value 0 means 2^LW samples.
REQ-006 SHALL have port s_valid, input, 1 bit, the input sample is valid.
REQ-007 SHALL have port s_ready, output, 1 bit, the block accepts a sample.
REQ-008 SHALL have port s_data, input, DW bits, unsigned input sample.
REQ-009 SHALL have port m_valid, output, 1 bit, the result is valid.
REQ-010 SHALL have port m_ready, input, 1 bit, the downstream consumer accepts the result.
REQ-011 SHALL have port m_max, output, DW bits, frame maximum.
REQ-012 SHALL have port m_idx, output, LW bits, zero-based position of the maximum within the frame.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-014 SHALL accept a beat only when s_valid and s_ready are both 1 in the same cycle.
REQ-015 IDLE: SHALL drive s_ready=1 and m_valid=0; on an accepted beat, SHALL latch cfg_len as the frame length and load the running max with s_data, the index with 0 and the beat count with 1.
REQ-016 IDLE: if the latched frame length is 1, SHALL go to HOLD; otherwise SHALL go to ACCUM.
REQ-017 ACCUM: SHALL drive s_ready=1; on each accepted beat, SHALL compare s_data to the running max through the max_core sub-module.
REQ-018 ACCUM: SHALL replace the running max and index only when s_data is strictly greater, so ties keep the earliest index.
REQ-019 ACCUM: on the accepted beat that makes the count equal to the frame length, SHALL go to HOLD.
REQ-020 HOLD: SHALL drive s_ready=0, m_valid=1, and keep m_max and m_idx stable until m_valid and m_ready are both 1.
REQ-021 HOLD: on the m_valid/m_ready handshake, SHALL go to IDLE; it SHALL NOT accept a new beat in that same cycle.
REQ-022 Latency: m_valid SHALL assert in the cycle after the last beat of the frame is accepted.
REQ-023 Throughput: at most one frame per frame-length + 1 cycles when m_ready is held at 1.
REQ-024 A change of cfg_len during a frame SHALL have no effect until the next IDLE accept.
REQ-025 The beat counter SHALL be LW+1 bits wide so that a frame of 2^LW samples does not wrap.
REQ-026 Gaps in s_valid SHALL stall accumulation without affecting the result.

Reset
REQ-027 rst=1 SHALL force state IDLE, s_ready=1, m_valid=0, m_max=0, m_idx=0, and clear the count and latched frame length, asynchronously.
REQ-028 A reset in the middle of a frame SHALL discard the partial frame; the first beat accepted after reset starts a new frame.

Configuration
REQ-029 SHALL use macro MAX_STREAM_APPROX_EN to select the comparison mode.
REQ-030 With MAX_STREAM_APPROX_EN defined, max_core SHALL compare only bits [DW-1:1] and force bit 0 of the selected maximum to 0, so m_max[0] is always 0.
REQ-031 With MAX_STREAM_APPROX_EN defined, samples equal in [DW-1:1] SHALL count as ties and keep the earlier index.
REQ-032 Without MAX_STREAM_APPROX_EN, max_core SHALL be exact over all DW bits.

Structure
REQ-033 A shared package max_pkg SHALL hold the FSM state enum, the DW and LW defaults, and the approximate-LSB mask constant.
REQ-034 SHALL contain one combinational sub-module max_core, with inputs a and b (DW bits) and outputs gt (1 bit) and max (DW bits); it is the only place the macro is tested.

Verification
REQ-035 Bench SHALL drive cfg_len=4, samples 3,17,9,17 with m_ready=1 -> m_max=17, m_idx=1, with m_valid asserted the cycle after the 4th beat.
REQ-036 Bench SHALL drive cfg_len=1, sample 42 -> the FSM goes from IDLE straight to HOLD, m_max=42, m_idx=0.
REQ-037 Bench SHALL drive cfg_len=0 (16 samples), values 0..15 ascending -> m_max=15, m_idx=15, and the counter does not wrap.
REQ-038 Bench SHALL hold m_ready=0 for 5 cycles in HOLD -> s_ready=0 and m_max/m_idx stable, then one handshake and a return to IDLE.
REQ-039 Bench SHALL assert rst after 2 of 4 beats, then send a fresh frame 5,1,2,0 -> m_max=5, m_idx=0, with no influence from the earlier beats.
REQ-040 Bench with MAX_STREAM_APPROX_EN SHALL drive cfg_len=2, samples 6,7 -> m_max=6, m_idx=0 (tie); the same stimulus without the macro -> m_max=7, m_idx=1.

Source files
------------

// File: rtl/max_pkg.sv
// Shared types and constants for the streaming frame-maximum controller.
// MAX_STREAM_APPROX_EN selects the approximate comparison mode in max_core.
package max_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DW_DEF = 6;
    localparam int LW_DEF = 4;

    // Clears the LSB of the selected maximum in approximate mode
    localparam logic [63:0] APPROX_MASK = ~64'd1;

endpackage

// File: rtl/max_core.sv
// Combinational compare/select between a candidate sample (a) and a running max (b).
// MAX_STREAM_APPROX_EN ignores bit 0 in the compare and clears it in the result.
module max_core
    import max_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          gt,
    output logic [DW-1:0] max
);

`ifdef MAX_STREAM_APPROX_EN
    localparam logic [DW-1:0] MASK = APPROX_MASK[DW-1:0];

    always_comb begin
        gt  = a[DW-1:1] > b[DW-1:1];
        max = (gt ? a : b) & MASK;
    end
`else
    always_comb begin
        gt  = a > b;
        max = gt ? a : b;
    end
`endif

endmodule

// File: rtl/max_stream_ctrl.sv
// Streams a frame of samples and reports its maximum and first index.
// Comparison mode is chosen in max_core via MAX_STREAM_APPROX_EN.
module max_stream_ctrl
    import max_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [LW-1:0] cfg_len,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_max,
    output logic [LW-1:0] m_idx
);

    localparam logic [LW:0] ONE = {{LW{1'b0}}, 1'b1};

    state_t        state;
    logic [LW:0]   cnt;
    logic [LW:0]   len;
    logic [LW:0]   cnt_next;
    logic [LW:0]   cfg_full;
    logic          accept;
    logic [DW-1:0] core_b;
    logic [DW-1:0] core_max;
    logic          core_gt;

    // Length 0 encodes a full 2^LW frame, hence the extra counter bit
    assign cfg_full = (cfg_len == '0) ? {1'b1, {LW{1'b0}}}
                                      : {1'b0, cfg_len};
    assign cnt_next = cnt + ONE;
    assign accept   = s_valid & s_ready;

    // First beat is also routed through the core so it sees the same masking
    assign core_b = (state == IDLE) ? '0 : m_max;

    max_core #(.DW(DW)) u_core (
        .a   (s_data),
        .b   (core_b),
        .gt  (core_gt),
        .max (core_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_max   <= '0;
            m_idx   <= '0;
            cnt     <= '0;
            len     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        len   <= cfg_full;
                        m_max <= core_max;
                        m_idx <= '0;
                        cnt   <= ONE;
                        if (cfg_full == ONE) begin
                            state   <= HOLD;
                            s_ready <= 1'b0;
                            m_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt_next;
                        if (core_gt) begin
                            m_max <= core_max;
                            m_idx <= cnt[LW-1:0];
                        end
                        if (cnt_next == len) begin
                            state   <= HOLD;
                            s_ready <= 1'b0;
                            m_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_valid && m_ready) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_stream_ctrl.sv
// Directed plus randomized frames against a frame-level reference model.
// Expectations follow MAX_STREAM_APPROX_EN when it is defined.
module tb_max_stream_ctrl;
    import max_pkg::*;

    localparam int DW = 6;
    localparam int LW = 4;

`ifdef MAX_STREAM_APPROX_EN
    localparam bit APPROX = 1'b1;
`else
    localparam bit APPROX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] cfg_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_max;
    logic [LW-1:0] m_idx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] samp [16];

    always #5 clk = ~clk;

    max_stream_ctrl #(.DW(DW), .LW(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_len (cfg_len),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_max   (m_max),
        .m_idx   (m_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int key(input logic [DW-1:0] v);
        return APPROX ? int'(v >> 1) : int'(v);
    endfunction

    // Frame result: largest key wins, earliest position on ties
    function automatic void model(input int n, output logic [DW-1:0] emax,
                                  output logic [LW-1:0] eidx);
        int bi;
        bi = 0;
        for (int i = 1; i < n; i++)
            if (key(samp[i]) > key(samp[bi])) bi = i;
        emax = samp[bi];
        if (APPROX) emax[0] = 1'b0;
        eidx = bi[LW-1:0];
    endfunction

    task automatic run_frame(input string tag, input logic [LW-1:0] cfg,
                             input int hold, input bit gaps,
                             input bit mrdy_hi);
        int            n;
        int            g;
        logic [DW-1:0] emax;
        logic [LW-1:0] eidx;
        n = (cfg == '0) ? 16 : int'(cfg);
        model(n, emax, eidx);
        m_ready = mrdy_hi;
        for (int i = 0; i < n; i++) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = DW'($urandom);
                if (i > 0) chk({tag, "_busy"}, 32'(m_valid), 32'd0);
            end
            @(negedge clk);
            if (i > 0) chk({tag, "_nodone"}, 32'(m_valid), 32'd0);
            chk({tag, "_srdy"}, 32'(s_ready), 32'd1);
            s_valid = 1'b1;
            s_data  = samp[i];
            cfg_len = (i == 0) ? cfg : LW'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
        chk({tag, "_hold_srdy"}, 32'(s_ready), 32'd0);
        chk({tag, "_max"}, 32'(m_max), 32'(emax));
        chk({tag, "_idx"}, 32'(m_idx), 32'(eidx));
        if (!mrdy_hi) begin
            repeat (hold) begin
                @(negedge clk);
                s_valid = 1'($urandom);
                s_data  = DW'($urandom);
                chk({tag, "_stall_v"}, 32'(m_valid), 32'd1);
                chk({tag, "_stall_r"}, 32'(s_ready), 32'd0);
                chk({tag, "_stall_max"}, 32'(m_max), 32'(emax));
                chk({tag, "_stall_idx"}, 32'(m_idx), 32'(eidx));
            end
            @(negedge clk);
            m_ready = 1'b1;
            s_valid = 1'b1;
            s_data  = DW'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk({tag, "_idle_v"}, 32'(m_valid), 32'd0);
        chk({tag, "_idle_r"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        cfg_len = '0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #3;
        chk("rst_srdy", 32'(s_ready), 32'd1);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_max", 32'(m_max), 32'd0);
        chk("rst_idx", 32'(m_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        samp[0] = 6'd3; samp[1] = 6'd17; samp[2] = 6'd9; samp[3] = 6'd17;
        run_frame("len4", 4'd4, 0, 1'b0, 1'b1);

        samp[0] = 6'd42;
        run_frame("len1", 4'd1, 0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) samp[i] = DW'(i);
        run_frame("len16", 4'd0, 0, 1'b0, 1'b1);

        samp[0] = 6'd20; samp[1] = 6'd33; samp[2] = 6'd8;
        run_frame("stall", 4'd3, 5, 1'b0, 1'b0);

        samp[0] = 6'd60; samp[1] = 6'd61;
        cfg_len = 4'd4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = samp[i];
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_srdy", 32'(s_ready), 32'd1);
        chk("midrst_mvalid", 32'(m_valid), 32'd0);
        chk("midrst_max", 32'(m_max), 32'd0);
        chk("midrst_idx", 32'(m_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        samp[0] = 6'd5; samp[1] = 6'd1; samp[2] = 6'd2; samp[3] = 6'd0;
        run_frame("afterrst", 4'd4, 0, 1'b0, 1'b0);

        samp[0] = 6'd6; samp[1] = 6'd7;
        run_frame("tie67", 4'd2, 1, 1'b0, 1'b0);

        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 16; i++) samp[i] = DW'($urandom);
            if (f % 3 == 0)
                for (int i = 1; i < 16; i++)
                    if ($urandom_range(0, 1) == 1) samp[i] = samp[0];
            run_frame("rand", LW'($urandom), $urandom_range(0, 3),
                      1'b1, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
